// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one uart_tx core between NUM_REQ byte requesters.
// Optional forced release of an idle lock: define ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                   clk_from_FPGA,
    input  logic                   rst_from_FPGA,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   grant_valid,
    output logic [GW-1:0]          grant_id,
    output logic                   lock_timeout
);

    if (NUM_REQ < 1 || NUM_REQ > 8 || LOCK_TIMEOUT < 2) begin : g_bad_param
        $error("uart_tx_arbiter: illegal parameterisation");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        LOCKED    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          grant_valid_q, grant_valid_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic          last_flag_q, last_flag_d;

    logic          win_found;
    logic [GW-1:0] win_idx;
    logic [GW-1:0] sel_idx;
    logic          sel_valid;
    logic [7:0]    sel_data;
    logic          sel_last;
    logic          accept;
    logic [GW-1:0] rr_next;
    logic [NUM_REQ-1:0] ready_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          lock_timeout_q, lock_timeout_d;
`endif

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!win_found && req_valid[j] && (((32'(rr_ptr_q) + i) % NUM_REQ) == j)) begin
                    win_found = 1'b1;
                    win_idx   = GW'(j);
                end
            end
        end
    end

    assign sel_idx = (state_q == IDLE) ? win_idx : grant_id_q;
    assign rr_next = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 8'h00;
        sel_last  = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (GW'(j) == sel_idx) begin
                sel_valid = req_valid[j];
                sel_data  = req_data[8*j +: 8];
                sel_last  = req_last[j];
            end
        end
    end

    // Next-state and capture logic
    always_comb begin
        state_d       = state_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        last_flag_d   = last_flag_q;
        accept        = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d      = '0;
        lock_timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!tx_busy && win_found) begin
                    accept = 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_flag_q) begin
                        state_d       = IDLE;
                        grant_valid_d = 1'b0;
                        rr_ptr_d      = rr_next;
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (sel_valid) begin
                    accept = 1'b1;
`ifdef ARB_TIMEOUT_EN
                end else if (tmo_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                    state_d        = IDLE;
                    grant_valid_d  = 1'b0;
                    rr_ptr_d       = rr_next;
                    lock_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d       = WAIT_BUSY;
            tx_start_d    = 1'b1;
            tx_data_d     = sel_data;
            grant_valid_d = 1'b1;
            grant_id_d    = sel_idx;
            last_flag_d   = sel_last;
        end
    end

    always_comb begin
        ready_c = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (accept && (GW'(j) == sel_idx)) begin
                ready_c[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_from_FPGA or posedge rst_from_FPGA) begin
        if (rst_from_FPGA) begin
            state_q       <= IDLE;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            last_flag_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            last_flag_q   <= last_flag_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk_from_FPGA or posedge rst_from_FPGA) begin
        if (rst_from_FPGA) begin
            tmo_cnt_q      <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q      <= tmo_cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign lock_timeout = lock_timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

    // Ready is held low for the whole reset assertion, not just after the first edge
    assign req_ready   = ready_c & ~{NUM_REQ{rst_from_FPGA}};
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx busy model.
// Expectations follow ARB_TIMEOUT_EN when that macro is defined for the build.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned FRAME = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0] req_last;
    logic [NREQ-1:0] req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic            grant_valid;
    logic [0:0]      grant_id;
    logic            lock_timeout;

    logic            model_busy;
    int              frame_cnt;
    logic            busy_force;

    int              checks = 0;
    int              errors = 0;
    int              pulses = 0;
    logic [15:0]     exp_q[$];
    logic [15:0]     exp_e;

    uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .GW           (1),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk_from_FPGA (clk),
        .rst_from_FPGA (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .lock_timeout  (lock_timeout)
    );

    always #5 clk = ~clk;

    // uart_tx model: busy rises the edge after tx_start and lasts FRAME cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_busy <= 1'b0;
            frame_cnt  <= 0;
        end else if (tx_start && !model_busy) begin
            model_busy <= 1'b1;
            frame_cnt  <= FRAME;
        end else if (model_busy) begin
            if (frame_cnt == 1) model_busy <= 1'b0;
            frame_cnt <= frame_cnt - 1;
        end
    end

    assign tx_busy = model_busy | busy_force;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every tx_start and watches invariants
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %0h expected none", tx_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(exp_e[7:0]));
                    chk("tx_grant_id", 32'(grant_id), 32'(exp_e[15:8]));
                    chk("ready_in_wait_busy", 32'(req_ready), 32'd0);
                end
            end
            if (lock_timeout) begin
                pulses++;
                chk("timeout_release", 32'(grant_valid), 32'd0);
            end
        end
    end

    task automatic send_byte(input int id, input logic [7:0] b, input logic last, input int budget);
        int n;
        n = 0;
        req_data[8*id +: 8] = b;
        req_last[id]        = last;
        req_valid[id]       = 1'b1;
        #1;
        while (!req_ready[id] && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("accept_req%0d_%0h", id, b), 32'(req_ready[id]), 32'd1);
        if (req_ready[id]) begin
            @(posedge clk);
            @(negedge clk);
            chk("tx_start_latency", 32'(tx_start), 32'd1);
        end
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic wait_release(input int budget);
        int n;
        n = 0;
        while (grant_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("release_in_budget", 32'(grant_valid), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        busy_force = 1'b0;

        // Reset values, with requests pending to prove ready is gated
        @(negedge clk);
        req_valid = 2'b11;
        req_last  = 2'b11;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_lock_timeout", 32'(lock_timeout), 32'd0);
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single byte from req0
        exp_q.push_back({8'd0, 8'h41});
        send_byte(0, 8'h41, 1'b1, 50);
        wait_release(200);

        // rr_ptr now 1: req1 wins a tie
        exp_q.push_back({8'd1, 8'h31});
        exp_q.push_back({8'd0, 8'h30});
        fork
            send_byte(1, 8'h31, 1'b1, 200);
            send_byte(0, 8'h30, 1'b1, 200);
        join
        wait_release(200);

        // Contention from reset: req0 first
        do_reset();
        exp_q.push_back({8'd0, 8'h30});
        exp_q.push_back({8'd1, 8'h31});
        fork
            send_byte(0, 8'h30, 1'b1, 200);
            send_byte(1, 8'h31, 1'b1, 200);
        join
        wait_release(200);

        // Packet lock: req1 "OK\n" is not interleaved with req0
        exp_q.push_back({8'd1, 8'h4F});
        exp_q.push_back({8'd1, 8'h4B});
        exp_q.push_back({8'd1, 8'h0A});
        exp_q.push_back({8'd0, 8'h5A});
        fork
            begin
                send_byte(1, 8'h4F, 1'b0, 200);
                send_byte(1, 8'h4B, 1'b0, 200);
                send_byte(1, 8'h0A, 1'b1, 200);
            end
            begin
                repeat (3) @(negedge clk);
                send_byte(0, 8'h5A, 1'b1, 400);
            end
        join
        wait_release(200);

        // Busy held in IDLE blocks the grant; dropping it grants the same cycle
        busy_force = 1'b1;
        @(negedge clk);
        req_data[7:0] = 8'h55;
        req_last[0]   = 1'b1;
        req_valid[0]  = 1'b1;
        repeat (5) begin
            #1;
            chk("busy_blocks_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        busy_force = 1'b0;
        exp_q.push_back({8'd0, 8'h55});
        #1;
        chk("busy_drop_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        wait_release(200);

        // Async reset while in WAIT_DONE mid-packet
        exp_q.push_back({8'd1, 8'h77});
        req_data[15:8] = 8'h77;
        req_last[1]    = 1'b0;
        req_valid[1]   = 1'b1;
        #1;
        chk("wd_accept", 32'(req_ready), 32'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("wd_pre_grant_id", 32'(grant_id), 32'd1);
        req_valid = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        chk("wd_rst_tx_start", 32'(tx_start), 32'd0);
        chk("wd_rst_tx_data", 32'(tx_data), 32'd0);
        chk("wd_rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("wd_rst_grant_id", 32'(grant_id), 32'd0);
        chk("wd_rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Owner idles in LOCKED while req1 waits
        exp_q.push_back({8'd0, 8'h10});
`ifndef ARB_TIMEOUT_EN
        exp_q.push_back({8'd0, 8'h11});
`endif
        exp_q.push_back({8'd1, 8'h20});
        fork
            send_byte(0, 8'h10, 1'b0, 50);
            begin
                repeat (2) @(negedge clk);
                send_byte(1, 8'h20, 1'b1, 3000);
            end
            begin
`ifndef ARB_TIMEOUT_EN
                repeat (1050) @(negedge clk);
                chk("lock_held_valid", 32'(grant_valid), 32'd1);
                chk("lock_held_id", 32'(grant_id), 32'd0);
                send_byte(0, 8'h11, 1'b1, 200);
`endif
            end
        join
        wait_release(200);
`ifdef ARB_TIMEOUT_EN
        chk("timeout_pulses", 32'(pulses), 32'd1);
`else
        chk("timeout_pulses", 32'(pulses), 32'd0);
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
